// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port unified memory between
// instruction fetch (i_*), load/store (d_*) and debug/loader (g_*) requesters.
// Fixed priority debug > data > fetch, with a guard that hands the memory to
// fetch after MAX_DATA_STREAK back-to-back data grants. Unanswered accesses
// are aborted after TIMEOUT cycles and answered with resp_err=1.
// Ports:
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_done/i_rdata          fetch requester
//   d_req/d_we/d_be/d_addr/d_wdata -> d_done/d_rdata   load/store requester
//   g_req/g_we/g_addr/g_wdata -> g_done/g_rdata        debug requester
//   resp_err                                 error flag, valid with any done
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata, mem_ack/mem_rdata   memory side
//   busy, owner                              status (owner: 0 none,1 I,2 D,3 G)
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [31:0]       g_wdata,
  output logic              g_done,
  output logic [31:0]       g_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned TCNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_G    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  // Command presented to memory; frozen for the whole ISSUE phase.
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [1:0]          owner_q, owner_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0]   g_rdata_q, g_rdata_d;
  logic [2:0]          done_q, done_d;   // {g, d, i}
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                fetch_forced_c;
  logic [1:0]          win_c;
  logic                timeout_hit_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign timeout_hit_c = (tcnt_q == TCNT_W'(TIMEOUT - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_req || d_req || g_req) state_d = S_ISSUE;
      S_ISSUE: if (mem_ack || timeout_hit_c) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Arbitration: fetch jumps ahead of data once the data streak is exhausted
  always_comb begin
    fetch_forced_c = i_req && !g_req && (streak_q == STREAK_W'(MAX_DATA_STREAK));
    win_c = OWN_NONE;
    if (g_req)               win_c = OWN_G;
    else if (fetch_forced_c) win_c = OWN_I;
    else if (d_req)          win_c = OWN_D;
    else if (i_req)          win_c = OWN_I;
  end

  // Output / datapath next values
  always_comb begin
    streak_d  = streak_q;
    tcnt_d    = tcnt_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    g_rdata_d = g_rdata_q;
    done_d    = 3'b000;
    err_d     = 1'b0;
    busy_d    = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        owner_d = win_c;
        if (win_c != OWN_NONE) begin
          mem_req_d = 1'b1;
          tcnt_d    = '0;
          unique case (win_c)
            OWN_G:   cmd_d = '{we: g_we, be: 4'hF, addr: g_addr, wdata: g_wdata};
            OWN_D:   cmd_d = '{we: d_we, be: (d_we ? d_be : 4'hF), addr: d_addr, wdata: d_wdata};
            default: cmd_d = '{we: 1'b0, be: 4'hF, addr: i_addr, wdata: '0};
          endcase
          // Streak only counts data grants that kept a waiting fetch out
          if (win_c == OWN_I || !i_req) begin
            streak_d = '0;
          end else if (win_c == OWN_D && streak_q != STREAK_W'(MAX_DATA_STREAK)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (mem_ack || timeout_hit_c) begin
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (!mem_ack) tcnt_d = TCNT_W'(TIMEOUT);
          unique case (owner_q)
            OWN_G:   done_d = 3'b100;
            OWN_D:   done_d = 3'b010;
            OWN_I:   done_d = 3'b001;
            default: done_d = 3'b000;
          endcase
          // Ack: reads update rdata, writes leave it. Timeout: rdata forced to 0.
          if (!mem_ack || !cmd_q.we) begin
            unique case (owner_q)
              OWN_G:   g_rdata_d = mem_ack ? mem_rdata : '0;
              OWN_D:   d_rdata_d = mem_ack ? mem_rdata : '0;
              OWN_I:   i_rdata_d = mem_ack ? mem_rdata : '0;
              default: ;
            endcase
          end
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_RESP: owner_d = OWN_NONE;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q  <= '0;
      tcnt_q    <= '0;
      owner_q   <= OWN_NONE;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      g_rdata_q <= '0;
      done_q    <= 3'b000;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      tcnt_q    <= tcnt_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      g_rdata_q <= g_rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign i_done    = done_q[0];
  assign d_done    = done_q[1];
  assign g_done    = done_q[2];
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign g_rdata   = g_rdata_q;
  assign resp_err  = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_be    = cmd_q.be;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed requester stimulus, a simple memory
// responder, and a scoreboard of expected grants and responses.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        g_req;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_done;
  logic [31:0] g_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  owner;

  unified_mem_arbiter #(.ADDR_W(32), .MAX_DATA_STREAK(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_done(g_done), .g_rdata(g_rdata),
    .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic [1:0]  own;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int last_done_cyc = 0;
  int req_len = 0;
  int last_req_len = 0;
  logic no_ack = 1'b0;
  logic req_prev = 1'b0;
  grant_t cur_g;
  resp_t  mon_r;
  logic [1:0]  mon_code;
  logic [31:0] mon_rdata;

  int exp_sim[3]    = '{3, 2, 1};
  int exp_starve[6] = '{2, 2, 2, 2, 1, 2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_g(input logic [1:0] o, input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd);
    grant_t g;
    g.own = o; g.addr = a; g.we = we; g.be = be; g.wdata = wd;
    exp_grant.push_back(g);
  endtask

  task automatic push_r(input logic [1:0] o, input logic [31:0] rd, input logic err);
    resp_t r;
    r.own = o; r.rdata = rd; r.err = err;
    exp_resp.push_back(r);
  endtask

  // Waits for any done pulse; returns 1=fetch, 2=data, 3=debug
  task automatic wait_done(input int budget, output logic [1:0] code);
    logic found;
    found = 1'b0;
    code  = 2'd0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk); #1;
      if (g_done || d_done || i_done) begin
        found = 1'b1;
        code  = g_done ? 2'd3 : (d_done ? 2'd2 : 2'd1);
      end
    end
    if (!found) chk("wait_done_timeout", 32'(found), 32'd1);
  endtask

  // Memory model: acks in the same cycle mem_req is seen unless no_ack is set
  always @(negedge clk) begin
    if (mem_req && !no_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_data(mem_addr);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  // Monitor: checks grants against the scoreboard while mem_req is high,
  // and each done pulse against the expected response.
  always @(negedge clk) begin
    ncyc++;
    if (mem_req) begin
      if (!req_prev) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(exp_grant.size()), 32'd1);
        else cur_g = exp_grant.pop_front();
        req_len = 0;
      end
      req_len++;
      chk("mem_owner", 32'(owner), 32'(cur_g.own));
      chk("mem_addr",  mem_addr,   cur_g.addr);
      chk("mem_we",    32'(mem_we), 32'(cur_g.we));
      chk("mem_be",    32'(mem_be), 32'(cur_g.be));
      chk("mem_wdata", mem_wdata,  cur_g.wdata);
    end else if (req_prev) begin
      last_req_len = req_len;
    end
    req_prev = mem_req;

    if (g_done || d_done || i_done) begin
      chk("done_onehot", 32'($countones({g_done, d_done, i_done})), 32'd1);
      mon_code  = g_done ? 2'd3 : (d_done ? 2'd2 : 2'd1);
      mon_rdata = g_done ? g_rdata : (d_done ? d_rdata : i_rdata);
      last_done_cyc = ncyc;
      chk("resp_owner", 32'(owner), 32'(mon_code));
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 32'(exp_resp.size()), 32'd1);
      end else begin
        mon_r = exp_resp.pop_front();
        chk("resp_who",   32'(mon_code), 32'(mon_r.own));
        chk("resp_rdata", mon_rdata,     mon_r.rdata);
        chk("resp_err",   32'(resp_err), 32'(mon_r.err));
      end
    end
  end

  initial begin
    logic [1:0] code;
    int c0;
    int dc[6];

    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset values
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_owner",   32'(owner),   32'd0);
    chk("rst_dones",   32'({g_done, d_done, i_done}), 32'd0);
    chk("rst_err",     32'(resp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be",  32'(mem_be), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_g_rdata", g_rdata, 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // Single fetch
    @(negedge clk); #1;
    push_g(2'd1, 32'h10, 1'b0, 4'hF, 32'h0);
    push_r(2'd1, 32'h0050_0093, 1'b0);
    i_req = 1'b1; i_addr = 32'h10; c0 = ncyc;
    wait_done(10, code);
    i_req = 1'b0;
    chk("t1_who", 32'(code), 32'd1);
    chk("t1_latency", 32'(last_done_cyc - c0), 32'd2);
    chk("t1_req_len", 32'(last_req_len), 32'd1);

    // Simultaneous requests: debug write, data read, fetch
    @(negedge clk); #1;
    push_g(2'd3, 32'h80,  1'b1, 4'hF, 32'h1234_5678);
    push_g(2'd2, 32'h200, 1'b0, 4'hF, 32'h1111_1111);
    push_g(2'd1, 32'h24,  1'b0, 4'hF, 32'h0);
    push_r(2'd3, 32'h0, 1'b0);
    push_r(2'd2, mem_data(32'h200), 1'b0);
    push_r(2'd1, mem_data(32'h24), 1'b0);
    g_req = 1'b1; g_we = 1'b1; g_addr = 32'h80; g_wdata = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h200; d_wdata = 32'h1111_1111;
    i_req = 1'b1; i_addr = 32'h24;
    for (int k = 0; k < 3; k++) begin
      wait_done(12, code);
      dc[k] = last_done_cyc;
      chk("t2_order", 32'(code), 32'(exp_sim[k]));
      if (code == 2'd3) g_req = 1'b0;
      if (code == 2'd2) d_req = 1'b0;
      if (code == 2'd1) i_req = 1'b0;
    end
    chk("t2_gap0", 32'(dc[1] - dc[0]), 32'd3);
    chk("t2_gap1", 32'(dc[2] - dc[1]), 32'd3);

    // Starvation guard: data and fetch held continuously
    @(negedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      if (exp_starve[k] == 2) begin
        push_g(2'd2, 32'h200, 1'b0, 4'hF, 32'h1111_1111);
        push_r(2'd2, mem_data(32'h200), 1'b0);
      end else begin
        push_g(2'd1, 32'h28, 1'b0, 4'hF, 32'h0);
        push_r(2'd1, mem_data(32'h28), 1'b0);
      end
    end
    d_req = 1'b1; d_addr = 32'h200; i_req = 1'b1; i_addr = 32'h28;
    for (int k = 0; k < 6; k++) begin
      wait_done(12, code);
      chk("t3_seq", 32'(code), 32'(exp_starve[k]));
      if (k == 5) begin
        d_req = 1'b0;
        i_req = 1'b0;
      end
    end

    // Partial store: d_rdata must keep the previous load value
    @(negedge clk); #1;
    push_g(2'd2, 32'h104, 1'b1, 4'b0011, 32'hCAFE_BABE);
    push_r(2'd2, mem_data(32'h200), 1'b0);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h104; d_wdata = 32'hCAFE_BABE;
    wait_done(10, code);
    d_req = 1'b0; d_we = 1'b0;
    chk("t4_who", 32'(code), 32'd2);

    // Timeout: memory never answers
    @(negedge clk); #1;
    no_ack = 1'b1;
    push_g(2'd2, 32'h300, 1'b0, 4'hF, 32'h0);
    push_r(2'd2, 32'h0, 1'b1);
    d_req = 1'b1; d_addr = 32'h300; d_wdata = 32'h0; d_be = 4'hF;
    wait_done(40, code);
    d_req = 1'b0;
    chk("t5_who", 32'(code), 32'd2);
    chk("t5_req_len", 32'(last_req_len), 32'd16);
    no_ack = 1'b0;

    // Reset in the middle of an access
    @(negedge clk); #1;
    no_ack = 1'b1;
    push_g(2'd1, 32'h40, 1'b0, 4'hF, 32'h0);
    i_req = 1'b1; i_addr = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_pre_req",  32'(mem_req), 32'd1);
    chk("t6_pre_busy", 32'(busy),    32'd1);
    reset = 1'b0;
    #1;
    chk("t6_req",   32'(mem_req), 32'd0);
    chk("t6_busy",  32'(busy),    32'd0);
    chk("t6_owner", 32'(owner),   32'd0);
    i_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t6_no_done", 32'({g_done, d_done, i_done}), 32'd0);
    end
    reset = 1'b1;
    no_ack = 1'b0;
    @(negedge clk); #1;
    push_g(2'd1, 32'h10, 1'b0, 4'hF, 32'h0);
    push_r(2'd1, 32'h0050_0093, 1'b0);
    i_req = 1'b1; i_addr = 32'h10;
    wait_done(10, code);
    i_req = 1'b0;
    chk("t6_fresh_who", 32'(code), 32'd1);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_grants_left", 32'(exp_grant.size()), 32'd0);
    chk("sb_resps_left",  32'(exp_resp.size()),  32'd0);
    chk("end_idle",       32'(busy),             32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
